uart_tx_arbiter: RTL and testbench

//  Shares one UART TX (serializer + frame FSM) between two byte requesters.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester front end for a shared UART TX: arbitrates, latches the byte, strobes TX and tracks BUSY.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default build is round-robin.
module uart_tx_arbiter #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_par_en,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_par_en,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_par_en,
    output logic                  tx_data_valid,
    input  logic                  tx_busy,
    output logic                  grant,
    output logic                  err_timeout
);

    localparam int unsigned       CNT_W    = $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] tx_data_d;
    logic                  tx_par_en_d;
    logic                  tx_data_valid_d;
    logic                  grant_d;
    logic                  err_timeout_d;
    logic                  winner_c;
    logic                  offer_c;

    // Winner selection; ptr_q holds the last requester served.
    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        winner_c = ~req0_valid;
`else
        winner_c = (req0_valid & req1_valid) ? ~ptr_q : ~req0_valid;
`endif
    end

    assign offer_c    = rst_n & (state_q == S_IDLE) & ~tx_busy;
    assign req0_ready = offer_c & req0_valid & ~winner_c;
    assign req1_ready = offer_c & req1_valid & winner_c;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ptr_d           = ptr_q;
        tx_data_d       = tx_data;
        tx_par_en_d     = tx_par_en;
        grant_d         = grant;
        tx_data_valid_d = 1'b0;
        err_timeout_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0_ready | req1_ready) begin
                    tx_data_d   = winner_c ? req1_data : req0_data;
                    tx_par_en_d = winner_c ? req1_par_en : req0_par_en;
                    grant_d     = winner_c;
                    ptr_d       = winner_c;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_data_valid_d = 1'b1;
                cnt_d           = '0;
                state_d         = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ptr_q         <= 1'b1;
            tx_data       <= '0;
            tx_par_en     <= 1'b0;
            tx_data_valid <= 1'b0;
            grant         <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            tx_data       <= tx_data_d;
            tx_par_en     <= tx_par_en_d;
            tx_data_valid <= tx_data_valid_d;
            grant         <= grant_d;
            err_timeout   <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a transaction-timing reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned BT = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_par_en, req0_ready;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_par_en, req1_ready;
    logic [DW-1:0] req1_data;
    logic [DW-1:0] tx_data;
    logic          tx_par_en, tx_data_valid, tx_busy, grant, err_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_par_en(req0_par_en), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_par_en(req1_par_en), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_par_en(tx_par_en), .tx_data_valid(tx_data_valid),
        .tx_busy(tx_busy), .grant(grant), .err_timeout(err_timeout)
    );

    typedef struct {
        int          e;
        logic        g;
        logic [DW-1:0] d;
        logic        p;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    bit   mon_en = 1'b0;
    bit   have_hold = 1'b0;
    logic [DW-1:0] hold_d;
    logic hold_p, hold_g;
    exp_t mon_r;

    // Reference model: arbiter is free again F+3 edges after an accept (or BT+2 on timeout).
    bit ptr;
    int free_edge, acc_e, frame_len;
    bit force_to, acc0_last, acc1_last, acc_flag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: consumes strobes and timeout pulses against the scoreboard queues.
    always begin
        @(posedge clk);
        edge_cnt = edge_cnt + 1;
        #1;
        if (mon_en) begin
            if (tx_data_valid) begin
                if (exp_q.size() == 0) begin
                    chk("strobe_unexpected", 32'(tx_data_valid), 32'(0));
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("strobe_edge", 32'(edge_cnt), 32'(mon_r.e));
                    chk("tx_data", 32'(tx_data), 32'(mon_r.d));
                    chk("tx_par_en", 32'(tx_par_en), 32'(mon_r.p));
                    chk("grant", 32'(grant), 32'(mon_r.g));
                    hold_d = mon_r.d; hold_p = mon_r.p; hold_g = mon_r.g;
                    have_hold = 1'b1;
                end
            end else if (exp_q.size() > 0 && exp_q[0].e <= edge_cnt) begin
                mon_r = exp_q.pop_front();
                chk("strobe_missing", 32'(tx_data_valid), 32'(1));
            end else if (exp_q.size() == 0 && have_hold) begin
                chk("hold_data", 32'(tx_data), 32'(hold_d));
                chk("hold_par", 32'(tx_par_en), 32'(hold_p));
                chk("hold_grant", 32'(grant), 32'(hold_g));
            end
            if (err_timeout) begin
                if (err_q.size() == 0) chk("err_unexpected", 32'(err_timeout), 32'(0));
                else chk("err_edge", 32'(edge_cnt), 32'(err_q.pop_front()));
            end else if (err_q.size() > 0 && err_q[0] <= edge_cnt) begin
                void'(err_q.pop_front());
                chk("err_missing", 32'(err_timeout), 32'(1));
            end
        end
    end

    // One cycle of stimulus: TX BUSY model, requesters, expected READY and expected transactions.
    task automatic drive(input int mode);
        int   e;
        bit   w, idle, e0, e1, busy;
        exp_t r;
        @(negedge clk);
        e = edge_cnt + 1;
        acc_flag = 1'b0;
        busy = 1'b0;
        if (frame_len > 0 && e >= acc_e + 2 && e <= acc_e + frame_len + 1) busy = 1'b1;
        else if (mode == 0 && e >= free_edge && $urandom_range(0, 9) == 0) busy = 1'b1;
        tx_busy = busy;
        case (mode)
            1: begin
                req0_valid = 1'b1; req0_data = 8'h11; req0_par_en = 1'b0;
                req1_valid = 1'b1; req1_data = 8'h22; req1_par_en = 1'b1;
            end
            2: begin
                req0_valid = 1'b1; req0_data = 8'hA5; req0_par_en = 1'b1;
                req1_valid = 1'b0;
            end
            3: begin
                req0_valid = 1'b0; req1_valid = 1'b1; req1_par_en = 1'b1;
                if (acc1_last || req1_data == '0) req1_data = DW'($urandom_range(1, 255));
            end
            4: begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            default: begin
                if (acc0_last || !req0_valid) begin
                    req0_valid = ($urandom_range(0, 2) != 0);
                    req0_data = DW'($urandom); req0_par_en = 1'($urandom);
                end else if ($urandom_range(0, 7) == 0) req0_valid = 1'b0;
                if (acc1_last || !req1_valid) begin
                    req1_valid = ($urandom_range(0, 2) != 0);
                    req1_data = DW'($urandom); req1_par_en = 1'($urandom);
                end else if ($urandom_range(0, 7) == 0) req1_valid = 1'b0;
            end
        endcase
        acc0_last = 1'b0;
        acc1_last = 1'b0;
        idle = (e >= free_edge) && !busy;
`ifdef ARB_FIXED_PRIO_EN
        w = !req0_valid;
`else
        w = (req0_valid && req1_valid) ? !ptr : !req0_valid;
`endif
        e0 = idle && req0_valid && !w;
        e1 = idle && req1_valid && w;
        #1;
        chk("ready0", 32'(req0_ready), 32'(e0));
        chk("ready1", 32'(req1_ready), 32'(e1));
        if (e0 || e1) begin
            r.e = e + 1; r.g = w;
            r.d = w ? req1_data : req0_data;
            r.p = w ? req1_par_en : req0_par_en;
            exp_q.push_back(r);
            ptr = w; acc_e = e; acc_flag = 1'b1;
            acc0_last = e0; acc1_last = e1;
            if (force_to) frame_len = 0;
            else if (mode == 2 || mode == 3) frame_len = 11;
            else frame_len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
            if (frame_len == 0) begin
                err_q.push_back(e + BT + 1);
                free_edge = e + BT + 2;
            end else begin
                free_edge = e + frame_len + 3;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'(0));
        chk({tag, "_tx_par_en"}, 32'(tx_par_en), 32'(0));
        chk({tag, "_tx_data_valid"}, 32'(tx_data_valid), 32'(0));
        chk({tag, "_grant"}, 32'(grant), 32'(0));
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'(0));
        chk({tag, "_ready0"}, 32'(req0_ready), 32'(0));
        chk({tag, "_ready1"}, 32'(req1_ready), 32'(0));
    endtask

    task automatic model_reset();
        exp_q.delete(); err_q.delete();
        have_hold = 1'b0;
        ptr = 1'b1; free_edge = edge_cnt + 1; acc_e = -100; frame_len = 0;
        acc0_last = 1'b0; acc1_last = 1'b0; acc_flag = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; tx_busy = 1'b0; force_to = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h5A; req0_par_en = 1'b1;
        req1_valid = 1'b1; req1_data = 8'h3C; req1_par_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        repeat (40) drive(2);
        repeat (120) drive(1);
        force_to = 1'b1;
        repeat (60) drive(2);
        force_to = 1'b0;
        repeat (1500) drive(0);
        repeat (40) drive(4);

        // Reset while the TX frame is in flight (WAIT_DONE, grant=1, non-zero byte).
        for (int i = 0; i < 60 && !acc_flag; i++) drive(3);
        chk("rst_setup_accept", 32'(acc_flag), 32'(1));
        repeat (5) drive(3);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tx_busy = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        repeat (60) drive(1);
        repeat (300) drive(0);
        repeat (40) drive(4);
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
        chk("err_q_drained", 32'(err_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
